prirv32_fetch_unit: RTL and testbench
=====================================

# prirv32_fetch_unit

Instruction fetch unit for the priRV32 core. Owns the program counter, issues word reads to instruction memory over a request/acknowledge interface, and buffers returned words with their PCs in a small FIFO. The FIFO output feeds the instruction decoder through a valid/ready handshake. A redirect from execute (branch, jump or trap) flushes the buffer and restarts fetch at a new address.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2: instruction buffer entries; power of two, minimum 2.

- clk_in  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- mem_req_o  output  1  memory read request (registered)
- mem_addr_o  output  32  word address of request (registered, bits [1:0] always 0)
- mem_ack_i  input  1  memory accepts request; mem_rdata_i valid this cycle
- mem_rdata_i  input  32  instruction word
- redirect_i  input  1  flush and restart fetch
- redirect_pc_i  input  32  new fetch address
- instr_valid_o  output  1  FIFO head valid
- instr_o  output  32  FIFO head instruction word
- instr_pc_o  output  32  FIFO head PC
- instr_ready_i  input  1  decoder consumes head
- misalign_o  output  1  one-cycle pulse: redirect_pc_i[1:0] != 0

## Operation
- Reset values: mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, misalign_o=0, FIFO count=0, state=IDLE.
- States:
  - IDLE: entered only from reset; next cycle goes to FETCH.
  - FETCH: mem_req_o=1.
  - STALL: FIFO full, mem_req_o=0.
  - DROP: stale request outstanding, mem_req_o=1.
- Memory rule: once mem_req_o is high, mem_req_o and mem_addr_o hold until the cycle mem_ack_i=1. The fetch unit never withdraws a request. At most one request is outstanding.
- FETCH, on ack without redirect:
  - Push {mem_addr_o, mem_rdata_i} into the FIFO.
  - mem_addr_o <= mem_addr_o+4; 32-bit wrap, 32'hFFFF_FFFC goes to 0.
  - If count after the push and any simultaneous pop equals FIFO_DEPTH, go to STALL; otherwise stay in FETCH with a back-to-back request.
- STALL: when count < FIFO_DEPTH, go to FETCH next cycle.
- FIFO:
  - instr_valid_o = (count != 0).
  - Pop when instr_valid_o && instr_ready_i.
  - Simultaneous push and pop leave count unchanged.
  - No bypass: a pushed word appears at the head no earlier than the next cycle.
- Redirect (redirect_i=1 in cycle t), priority over push and pop:
  - Flush the FIFO; instr_valid_o=0 at t+1.
  - Load target = {redirect_pc_i[31:2], 2'b00}; misalign_o=1 at t+1 if redirect_pc_i[1:0] != 0.
  - mem_req_o high and mem_ack_i low at t: go to DROP. The old request stays held; its data is discarded on ack; the next cycle goes to FETCH at target.
  - mem_ack_i high at t, or mem_req_o low: the returned word is discarded; FETCH at target from t+1.
  - Redirect while in DROP: target is replaced; stay in DROP.
- rst_n low in any state: everything returns to reset values at the next edge, including any outstanding request. Memory must tolerate an abandoned request under reset.

## Timing
- First cycle with rst_n high is IDLE; mem_req_o=1, mem_addr_o=RESET_PC from the following cycle.
- Ack in cycle k: instr_valid_o=1 with that word from k+1.
- Zero-wait memory (ack whenever requested) with instr_ready_i held high sustains 1 instruction per cycle.
- Redirect at t with no pending request: mem_req_o=1 with mem_addr_o=target at t+1; earliest new instruction valid at t+2.
- With FIFO_DEPTH=2 and instr_ready_i low, exactly 2 words are fetched, then mem_req_o drops.

## Test plan
- Reset, zero-wait memory returning addr^32'hA5A5_0000, ready=1:
  - Addresses 0,4,8,… issued on consecutive cycles.
  - instr_pc_o/instr_o match each address and its data, one per cycle.
  - First valid 2 cycles after reset release.
- ready=0, zero-wait memory:
  - After 2 acks, mem_req_o=0 and the head holds PC 0.
  - Raising ready for 1 cycle pops PC 0; mem_req_o=1 at addr 8 the next cycle.
- Memory acks 3 cycles after request; redirect_i to 32'h100 during the wait:
  - mem_addr_o stays at the old address until ack; that data never appears.
  - Next request at 32'h100.
- Redirect coincident with ack and pop:
  - FIFO empty next cycle; the acked word is dropped.
  - Request at target the following cycle.
- redirect_pc_i=32'h203: misalign_o pulses 1 cycle; fetch resumes at 32'h200.
- RESET_PC=32'hFFFF_FFF8:
  - Fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Assert rst_n low mid-wait: all outputs return to reset values next edge.

Source files
------------

// File: rtl/prirv32_fetch_unit.sv
// ---------------------------------------------------------------------------
// prirv32_fetch_unit
// Instruction fetch unit for the priRV32 core.  Holds the program counter,
// issues one word read at a time to instruction memory, and buffers returned
// words with their PCs in a small FIFO.  The decoder reads the FIFO head
// through a valid/ready handshake.  A redirect from execute flushes the FIFO
// and restarts fetch at a new word-aligned address.
//
// Parameters
//   RESET_PC      first fetch address after reset (word aligned)
//   FIFO_DEPTH    instruction buffer entries (power of two, >= 2)
//
// Ports
//   clk_in          clock, rising edge
//   rst_n           synchronous active-low reset
//   mem_req_o       memory read request (registered, held until ack)
//   mem_addr_o      word address of the request (registered)
//   mem_ack_i       memory accepts request, mem_rdata_i valid this cycle
//   mem_rdata_i     returned instruction word
//   redirect_i      flush and restart fetch at redirect_pc_i
//   redirect_pc_i   new fetch address (low two bits ignored)
//   instr_valid_o   FIFO head valid
//   instr_o         FIFO head instruction word
//   instr_pc_o      FIFO head PC
//   instr_ready_i   decoder consumes the head this cycle
//   misalign_o      one-cycle pulse after a redirect with non-zero low bits
// ---------------------------------------------------------------------------
module prirv32_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk_in,
   input  logic        rst_n,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i,
   output logic        misalign_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_STALL = 2'd2,
      ST_DROP  = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_next_s;
   logic          mem_req_r;
   logic          mem_req_next_s;
   logic [31:0]   mem_addr_r;
   logic [31:0]   mem_addr_next_s;
   logic [31:0]   target_r;
   logic [31:0]   target_next_s;
   logic          misalign_r;

   logic [31:0]   fifo_instr_r [FIFO_DEPTH];
   logic [31:0]   fifo_pc_r    [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;

   logic          push_s;
   logic          pop_s;
   logic [31:0]   redirect_tgt_s;

   // Next-state, next-address and FIFO control decode
   always_comb begin
      state_next_s    = state_r;
      mem_addr_next_s = mem_addr_r;
      target_next_s   = target_r;
      redirect_tgt_s  = {redirect_pc_i[31:2], 2'b00};
      // A redirect discards both the returning word and the head consumption.
      push_s          = (state_r == ST_FETCH) && mem_ack_i && !redirect_i;
      pop_s           = (count_r != {CW{1'b0}}) && instr_ready_i && !redirect_i;
      count_next_s    = count_r + CW'(push_s) - CW'(pop_s);

      if (redirect_i) begin
         if (mem_req_r && !mem_ack_i) begin
            // Request cannot be withdrawn: keep it, park the target.
            state_next_s  = ST_DROP;
            target_next_s = redirect_tgt_s;
         end else begin
            state_next_s    = ST_FETCH;
            mem_addr_next_s = redirect_tgt_s;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
               if (mem_ack_i) begin
                  mem_addr_next_s = mem_addr_r + 32'd4;
                  if (count_next_s == DEPTH_C) begin
                     state_next_s = ST_STALL;
                  end else begin
                     state_next_s = ST_FETCH;
                  end
               end else begin
                  state_next_s = ST_FETCH;
               end
            end
            ST_STALL: begin
               if (count_next_s < DEPTH_C) begin
                  state_next_s = ST_FETCH;
               end else begin
                  state_next_s = ST_STALL;
               end
            end
            ST_DROP: begin
               if (mem_ack_i) begin
                  state_next_s    = ST_FETCH;
                  mem_addr_next_s = target_r;
               end else begin
                  state_next_s = ST_DROP;
               end
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase
      end

      mem_req_next_s = (state_next_s == ST_FETCH) || (state_next_s == ST_DROP);
   end

   // State, request and address registers
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         mem_req_r  <= 1'b0;
         mem_addr_r <= RESET_PC;
         target_r   <= RESET_PC;
         misalign_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         mem_req_r  <= mem_req_next_s;
         mem_addr_r <= mem_addr_next_s;
         target_r   <= target_next_s;
         misalign_r <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      end
   end

   // Instruction FIFO storage, pointers and occupancy
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr_r[i] <= 32'h0000_0000;
            fifo_pc_r[i]    <= 32'h0000_0000;
         end
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (redirect_i) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            fifo_instr_r[wr_ptr_r] <= mem_rdata_i;
            fifo_pc_r[wr_ptr_r]    <= mem_addr_r;
            wr_ptr_r               <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_next_s;
      end
   end

   assign mem_req_o     = mem_req_r;
   assign mem_addr_o    = mem_addr_r;
   assign misalign_o    = misalign_r;
   assign instr_valid_o = (count_r != {CW{1'b0}});
   assign instr_o       = fifo_instr_r[rd_ptr_r];
   assign instr_pc_o    = fifo_pc_r[rd_ptr_r];

endmodule

// File: tb/tb_prirv32_fetch_unit.sv
module tb_prirv32_fetch_unit;

   logic        clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // DUT 1: default RESET_PC, memory with programmable ack delay
   logic        rst_n;
   logic        mem_req, mem_ack, redirect, instr_valid, instr_ready, misalign;
   logic [31:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;
   int          ack_delay = 0;
   int          wait_cnt  = 0;

   // DUT 2: RESET_PC near the top of the address space, zero-wait memory
   logic        rst2_n;
   logic        mem_req2, mem_ack2, redirect2, instr_valid2, instr_ready2, misalign2;
   logic [31:0] mem_addr2, mem_rdata2, redirect_pc2, instr2, instr_pc2;

   int checks = 0;
   int errors = 0;

   prirv32_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
      .clk_in(clk_in), .rst_n(rst_n),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr),
      .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
      .instr_ready_i(instr_ready), .misalign_o(misalign)
   );

   prirv32_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut2 (
      .clk_in(clk_in), .rst_n(rst2_n),
      .mem_req_o(mem_req2), .mem_addr_o(mem_addr2),
      .mem_ack_i(mem_ack2), .mem_rdata_i(mem_rdata2),
      .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
      .instr_valid_o(instr_valid2), .instr_o(instr2), .instr_pc_o(instr_pc2),
      .instr_ready_i(instr_ready2), .misalign_o(misalign2)
   );

   // Memory models: data is address xor a fixed pattern
   assign mem_rdata  = mem_addr  ^ 32'hA5A5_0000;
   assign mem_rdata2 = mem_addr2 ^ 32'hA5A5_0000;
   assign mem_ack    = mem_req && (wait_cnt >= ack_delay);
   assign mem_ack2   = mem_req2;

   // Cycles the current request has been waiting
   always @(posedge clk_in) begin
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Ends in the first cycle with rst_n high (IDLE)
   task automatic do_reset();
      rst_n = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      instr_ready = 1'b1; ack_delay = 0;
      tick(); tick();
      checks++;
      if ({mem_req, mem_addr, instr_valid, misalign} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_ctrl got req=%b addr=%h valid=%b mis=%b want 0 00000000 0 0",
                  mem_req, mem_addr, instr_valid, misalign);
      end
      checks++;
      if ({instr_pc, instr} !== 64'h0) begin
         errors++;
         $display("FAIL reset_head got pc=%h instr=%h want 0 0", instr_pc, instr);
      end
      rst_n = 1'b1;
      checks++;
      if ({mem_req, instr_valid} !== 2'b00) begin
         errors++;
         $display("FAIL idle_cycle got req=%b valid=%b want 0 0", mem_req, instr_valid);
      end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      tick();
      checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL first_req got req=%b addr=%h valid=%b want 1 00000000 0",
                  mem_req, mem_addr, instr_valid);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         e = 32'(4 * i);
         checks++;
         if ({instr_valid, instr_pc, instr, mem_req, mem_addr} !==
             {1'b1, e, e ^ 32'hA5A5_0000, 1'b1, e + 32'd4}) begin
            errors++;
            $display("FAIL stream[%0d] got v=%b pc=%h ins=%h req=%b addr=%h want 1 %h %h 1 %h",
                     i, instr_valid, instr_pc, instr, mem_req, mem_addr,
                     e, e ^ 32'hA5A5_0000, e + 32'd4);
         end
      end
   endtask

   task automatic test_stall();
      instr_ready = 1'b0; ack_delay = 0;
      do_reset();
      tick(); tick(); tick();
      checks++;
      if ({mem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL stall_full got req=%b v=%b pc=%h want 0 1 00000000", mem_req, instr_valid, instr_pc);
      end
      tick();
      checks++;
      if ({mem_req, instr_pc, instr} !== {1'b0, 32'h0, 32'hA5A5_0000}) begin
         errors++;
         $display("FAIL stall_hold got req=%b pc=%h ins=%h want 0 00000000 a5a50000", mem_req, instr_pc, instr);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      checks++;
      if ({mem_req, mem_addr, instr_valid, instr_pc} !== {1'b1, 32'h8, 1'b1, 32'h4}) begin
         errors++;
         $display("FAIL stall_resume got req=%b addr=%h v=%b pc=%h want 1 00000008 1 00000004",
                  mem_req, mem_addr, instr_valid, instr_pc);
      end
      tick();
      checks++;
      if ({mem_req, instr_pc} !== {1'b0, 32'h4}) begin
         errors++;
         $display("FAIL stall_refill got req=%b pc=%h want 0 00000004", mem_req, instr_pc);
      end
   endtask

   task automatic test_redirect_wait();
      instr_ready = 1'b1; ack_delay = 3;
      do_reset();
      tick(); tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL drop_hold got req=%b addr=%h v=%b want 1 00000000 0", mem_req, mem_addr, instr_valid);
      end
      tick();
      checks++;
      if ({mem_req, mem_addr, mem_ack} !== {1'b1, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL drop_ack got req=%b addr=%h ack=%b want 1 00000000 1", mem_req, mem_addr, mem_ack);
      end
      tick();
      checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
         errors++;
         $display("FAIL drop_target got req=%b addr=%h v=%b want 1 00000100 0", mem_req, mem_addr, instr_valid);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_discard[%0d] got v=%b pc=%h want v=0", k, instr_valid, instr_pc);
         end
      end
      tick();
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, 32'hA5A5_0100}) begin
         errors++;
         $display("FAIL drop_newword got v=%b pc=%h ins=%h want 1 00000100 a5a50100",
                  instr_valid, instr_pc, instr);
      end
   endtask

   task automatic test_redirect_ack_pop();
      instr_ready = 1'b1; ack_delay = 0;
      do_reset();
      tick(); tick(); tick();
      checks++;
      if ({instr_valid, instr_pc, mem_ack} !== {1'b1, 32'h4, 1'b1}) begin
         errors++;
         $display("FAIL rap_pre got v=%b pc=%h ack=%b want 1 00000004 1", instr_valid, instr_pc, mem_ack);
      end
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      checks++;
      if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h40}) begin
         errors++;
         $display("FAIL rap_flush got v=%b req=%b addr=%h want 0 1 00000040", instr_valid, mem_req, mem_addr);
      end
      tick();
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h40, 32'hA5A5_0040}) begin
         errors++;
         $display("FAIL rap_new got v=%b pc=%h ins=%h want 1 00000040 a5a50040", instr_valid, instr_pc, instr);
      end
   endtask

   task automatic test_misalign();
      redirect = 1'b1; redirect_pc = 32'h203;
      tick();
      redirect = 1'b0;
      checks++;
      if ({misalign, instr_valid, mem_req, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h200}) begin
         errors++;
         $display("FAIL mis_pulse got mis=%b v=%b req=%b addr=%h want 1 0 1 00000200",
                  misalign, instr_valid, mem_req, mem_addr);
      end
      tick();
      checks++;
      if ({misalign, instr_valid, instr_pc, instr} !== {1'b0, 1'b1, 32'h200, 32'hA5A5_0200}) begin
         errors++;
         $display("FAIL mis_resume got mis=%b v=%b pc=%h ins=%h want 0 1 00000200 a5a50200",
                  misalign, instr_valid, instr_pc, instr);
      end
   endtask

   task automatic test_reset_mid_wait();
      instr_ready = 1'b1; ack_delay = 3;
      do_reset();
      tick(); tick();
      checks++;
      if ({mem_req, mem_addr, mem_ack} !== {1'b1, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL midrst_pre got req=%b addr=%h ack=%b want 1 00000000 0", mem_req, mem_addr, mem_ack);
      end
      rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h203;
      tick();
      checks++;
      if ({mem_req, mem_addr, instr_valid, misalign, instr_pc, instr} !==
          {1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL midrst got req=%b addr=%h v=%b mis=%b pc=%h ins=%h want all 0",
                  mem_req, mem_addr, instr_valid, misalign, instr_pc, instr);
      end
      rst_n = 1'b1; redirect = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] seq [3];
      seq[0] = 32'hFFFF_FFF8; seq[1] = 32'hFFFF_FFFC; seq[2] = 32'h0000_0000;
      redirect2 = 1'b0; redirect_pc2 = 32'h0; instr_ready2 = 1'b1;
      rst2_n = 1'b0;
      tick();
      rst2_n = 1'b1;
      checks++;
      if ({mem_req2, mem_addr2, instr_valid2} !== {1'b0, 32'hFFFF_FFF8, 1'b0}) begin
         errors++;
         $display("FAIL wrap_reset got req=%b addr=%h v=%b want 0 fffffff8 0", mem_req2, mem_addr2, instr_valid2);
      end
      tick();
      checks++;
      if ({mem_req2, mem_addr2} !== {1'b1, 32'hFFFF_FFF8}) begin
         errors++;
         $display("FAIL wrap_first got req=%b addr=%h want 1 fffffff8", mem_req2, mem_addr2);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({instr_valid2, instr_pc2, instr2, mem_addr2} !==
             {1'b1, seq[i], seq[i] ^ 32'hA5A5_0000, seq[i] + 32'd4}) begin
            errors++;
            $display("FAIL wrap[%0d] got v=%b pc=%h ins=%h addr=%h want 1 %h %h %h",
                     i, instr_valid2, instr_pc2, instr2, mem_addr2,
                     seq[i], seq[i] ^ 32'hA5A5_0000, seq[i] + 32'd4);
         end
      end
   endtask

   initial begin
      rst2_n = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0; instr_ready2 = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_wait();
      test_redirect_ack_pop();
      test_misalign();
      test_reset_mid_wait();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
